// File: rtl/fifo_main_param.sv
// fifo_main_param: main-buffer FIFO that sits between the input stage and the
// virtual-channel demux. It has a separate full-width occupancy count,
// almost-full/almost-empty thresholds that can be changed at runtime, a
// registered pop port with a valid strobe, pause hysteresis and a registered
// error flag.
//
// Parameters: DATA_SIZE (word width), ADDR_SIZE (pointer width, DEPTH = 2**ADDR_SIZE)
// Ports:
//   clk, reset                - rising-edge clock, asynchronous active-high reset
//   push, pop, data_in        - write request, read request, write data
//   af_thr, ae_thr            - almost-full / almost-empty thresholds (live inputs)
//   err_clr                   - clears the sticky error flag
//   data_out, data_valid      - registered pop data and its one-cycle strobe
//   data_count                - occupancy, 0..DEPTH
//   fifo_empty, fifo_full     - count==0 / count==DEPTH
//   almost_full, almost_empty - threshold flags, derived combinationally from count
//   pause                     - registered flow-control request, with hysteresis
//   error                     - registered protocol-violation flag
// Build option: FIFO_ERR_STICKY_EN makes error sticky until err_clr.
module fifo_main_param #(
   parameter int unsigned DATA_SIZE = 6,
   parameter int unsigned ADDR_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic [ADDR_SIZE:0]   af_thr,
   input  logic [ADDR_SIZE:0]   ae_thr,
   input  logic                 err_clr,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 data_valid,
   output logic [ADDR_SIZE:0]   data_count,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 pause,
   output logic                 error
);

   localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
   localparam logic [ADDR_SIZE:0]   FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};
   localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
   localparam logic [ADDR_SIZE-1:0] PTR_ONE  = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

   logic [DATA_SIZE-1:0] mem [DEPTH];
   logic [ADDR_SIZE-1:0] wr_ptr;
   logic [ADDR_SIZE-1:0] rd_ptr;
   logic [ADDR_SIZE:0]   count;
   logic                 push_ok;
   logic                 pop_ok;
   logic                 err_cond;

   always_comb begin
      fifo_empty   = (count == '0);
      fifo_full    = (count == FULL_CNT);
      almost_full  = (count >= af_thr);
      almost_empty = (count <= ae_thr) && (count != '0);
      pop_ok       = pop & ~fifo_empty;
      // When the FIFO is full, a push is accepted only together with a successful pop.
      push_ok      = push & (~fifo_full | pop_ok);
      err_cond     = (push & fifo_full & ~pop_ok) | (pop & fifo_empty);
   end

   assign data_count = count;

   // The storage array has no reset; its contents cannot be observed until they have been written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         pause      <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= mem[rd_ptr];
         end
         data_valid <= pop_ok;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // Pause hysteresis: raise at almost-full, drop at or below ae_thr, otherwise hold.
         if (almost_full)           pause <= 1'b1;
         else if (count <= ae_thr)  pause <= 1'b0;
      end
   end

`ifdef FIFO_ERR_STICKY_EN
   // A new violation takes priority over err_clr in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) error <= 1'b0;
      else       error <= err_cond | (error & ~err_clr);
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) error <= 1'b0;
      else       error <= err_cond;
   end
`endif

endmodule

// File: doc/fifo_main_param.md
# fifo_main_param

Parametrised successor of the main-buffer FIFO, sitting between the input stage and the virtual-channel demux. It adds runtime-programmable thresholds on a full-width occupancy count, a registered pop output with valid strobe, and hysteresis on the pause (flow-control) output. It also adds registered error reporting that can optionally be made sticky, and handles simultaneous push/pop correctly at both full and empty.

## Interface
- DATA_SIZE, 6, data word width in bits
- ADDR_SIZE, 3, pointer width; depth DEPTH = 2**ADDR_SIZE
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- push  input  1  write request
- pop  input  1  read request
- data_in  input  DATA_SIZE  write data
- af_thr  input  ADDR_SIZE+1  almost-full threshold (live, unregistered)
- ae_thr  input  ADDR_SIZE+1  almost-empty threshold (live, unregistered)
- err_clr  input  1  clears sticky error
- data_out  output  DATA_SIZE  registered pop data
- data_valid  output  1  data_out holds a newly popped word this cycle
- data_count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH
- fifo_empty, fifo_full  output  1  each; count==0 / count==DEPTH
- almost_full, almost_empty  output  1  each; threshold flags
- pause  output  1  registered flow-control request to upstream
- error  output  1  registered protocol-violation flag

## Operation
- Storage: DEPTH x DATA_SIZE array; wr_ptr and rd_ptr are ADDR_SIZE bits and wrap naturally DEPTH-1 -> 0; count held separately (ADDR_SIZE+1 bits, never wraps).
- Accept rules:
  - push_ok = push & (!fifo_full | pop_ok)
  - pop_ok = pop & !fifo_empty
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Full + push + pop: both accepted, count stays DEPTH, no error.
- Empty + push + pop: push accepted, pop rejected, count -> 1, error raised.
- Combinational flags from registered count:
  - almost_full = count >= af_thr
  - almost_empty = (count <= ae_thr) & (count != 0)
- Pause hysteresis, registered each cycle: if almost_full, pause <= 1; else if count <= ae_thr, pause <= 0; else hold.
- Error condition: (push & fifo_full & !pop_ok) | (pop & fifo_empty).
  - Registered: error = 1 the cycle after the offending request.
- Rejected operations never move pointers, count or memory.
- Reset, asynchronous and valid mid-operation: pointers, count, data_out, data_valid, pause and error all go to 0. fifo_empty = 1, all other flags 0. Memory contents are not cleared and are unobservable.

## Timing
- Push: word written at the clk edge where push_ok; visible in data_count the same edge.
- Pop latency: data_out and data_valid update on the edge where pop_ok; data_valid high for exactly one cycle per accepted pop; data_out holds its value otherwise.
- Back-to-back pops stream one word per cycle.
- Flags follow count combinationally with no extra latency.
- pause and error lag their conditions by one cycle.
- Threshold changes take effect on flags immediately and on pause at the next edge.

## Configuration
- FIFO_ERR_STICKY_EN defined: error sets on any violation and holds until a cycle with err_clr=1 and no new violation. Violation and err_clr in the same cycle keep error = 1 (set wins).
- Undefined: error is a one-cycle pulse per violating cycle; err_clr is ignored.

## Test plan
- Reset, push 8 words 0x01..0x08 (DATA_SIZE=6, ADDR_SIZE=3), af_thr=6, ae_thr=2 -> fifo_full=1, data_count=8, almost_full from count 6, pause=1 one cycle after count reaches 6, error=0.
- Pop all 8 -> data_out 0x01..0x08 in order with data_valid each cycle. pause stays 1 until count<=2, then 0 one cycle later. fifo_empty=1 at count 0.
- At full, push+pop together for 4 cycles -> count stays 8, error=0, popped order preserved across pointer wrap.
- Pop on empty -> error=1 next cycle, count stays 0, data_valid=0. With FIFO_ERR_STICKY_EN, error holds until err_clr; without it, error lasts one cycle.
- Empty + push+pop same cycle -> count=1, data_valid=0, error=1; then a pop returns the pushed word.
- Assert reset mid-stream at count=5 -> all outputs to reset values immediately without a clock. After release, a push/pop of 0x2A returns 0x2A.
